// File: rtl/wisc_pkg.sv
// Shared definitions for the flag/branch unit: flag bit positions, branch
// condition encodings and the run/halt state encoding.
package wisc_pkg;

  // Bit positions within the 3-bit flag vector.
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagV = 0;

  // Branch condition codes.
  localparam logic [2:0] CondNe  = 3'b000;  // Z=0
  localparam logic [2:0] CondEq  = 3'b001;  // Z=1
  localparam logic [2:0] CondGt  = 3'b010;  // Z=0 & N=0
  localparam logic [2:0] CondLt  = 3'b011;  // N=1
  localparam logic [2:0] CondGe  = 3'b100;  // Z=1 | (Z=0 & N=0)
  localparam logic [2:0] CondLe  = 3'b101;  // N=1 | Z=1
  localparam logic [2:0] CondOvf = 3'b110;  // V=1
  localparam logic [2:0] CondAl  = 3'b111;  // always

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator.
// Ports:
//   cond_i  - 3-bit condition code
//   flags_i - flag vector {N, Z, V}
//   true_o  - condition holds for the given flags
module cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       true_o
);

  logic n, z, v;

  assign n = flags_i[FlagN];
  assign z = flags_i[FlagZ];
  assign v = flags_i[FlagV];

  always_comb begin
    true_o = 1'b0;
    unique case (cond_i)
      CondNe:  true_o = ~z;
      CondEq:  true_o = z;
      CondGt:  true_o = ~z & ~n;
      CondLt:  true_o = n;
      CondGe:  true_o = z | (~z & ~n);
      CondLe:  true_o = n | z;
      CondOvf: true_o = v;
      CondAl:  true_o = 1'b1;
      default: true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch resolution and PC register with a run/halt state.
// Optional macro FLAG_BYPASS_EN: when defined, conditions are evaluated on
// flags merged with the same-cycle flag writes; otherwise on flags_q only.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   flags_in, flags_en   - new flag values {N,Z,V} and per-bit write enables
//   is_branch, is_br_reg - branch instruction, register (BR) vs immediate (B)
//   cond, imm9           - condition code, signed word offset for B
//   reg_target           - BR target address
//   is_hlt, stall        - halt instruction, hold PC and state this cycle
//   pc_out, pc_plus2     - current PC and PC+2
//   taken, halt, flags_q - branch taken (comb), halted state, flag register
module flag_branch_unit
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  flags_in,
  input  logic [2:0]  flags_en,
  input  logic        is_branch,
  input  logic        is_br_reg,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] reg_target,
  input  logic        is_hlt,
  input  logic        stall,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic        halt,
  output logic [2:0]  flags_q
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_d;
  logic [2:0]  flags_eval;
  logic        cond_true;
  logic        run;
  logic [15:0] target;

  assign run = (state_q == StRun);

`ifdef FLAG_BYPASS_EN
  assign flags_eval = (flags_in & flags_en) | (flags_q & ~flags_en);
`else
  assign flags_eval = flags_q;
`endif

  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (flags_eval),
    .true_o  (cond_true)
  );

  assign pc_plus2 = pc_q + 16'd2;
  assign taken    = is_branch & cond_true & run & ~is_hlt;
  // Sign-extended word offset scaled to bytes; arithmetic wraps at 16 bits.
  assign target   = is_br_reg ? reg_target
                              : pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

  always_comb begin
    pc_d    = pc_q;
    flags_d = flags_q;
    state_d = state_q;
    if (run && !stall) begin
      flags_d = (flags_in & flags_en) | (flags_q & ~flags_en);
      if (is_hlt) begin
        state_d = StHalted;
      end else if (taken) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= 16'h0000;
      flags_q <= 3'b000;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end

  assign pc_out = pc_q;
  assign halt   = (state_q == StHalted);

endmodule

// File: tb/tb_flag_branch_unit.sv
module tb_flag_branch_unit;

`ifdef FLAG_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  flags_in, flags_en;
  logic        is_branch, is_br_reg, is_hlt, stall;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] reg_target;
  logic [15:0] pc_out, pc_plus2;
  logic        taken, halt;
  logic [2:0]  flags_q;

  flag_branch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .flags_in   (flags_in),
    .flags_en   (flags_en),
    .is_branch  (is_branch),
    .is_br_reg  (is_br_reg),
    .cond       (cond),
    .imm9       (imm9),
    .reg_target (reg_target),
    .is_hlt     (is_hlt),
    .stall      (stall),
    .pc_out     (pc_out),
    .pc_plus2   (pc_plus2),
    .taken      (taken),
    .halt       (halt),
    .flags_q    (flags_q)
  );

  // Negedge comes first so each cycle's check precedes its active edge.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        tk;
    logic        h;
    logic [2:0]  fl;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; check every pending expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc_out",  pc_out,          e.pc);
      chk(e.name, "taken",   {15'd0, taken},  {15'd0, e.tk});
      chk(e.name, "halt",    {15'd0, halt},   {15'd0, e.h});
      chk(e.name, "flags_q", {13'd0, flags_q}, {13'd0, e.fl});
    end
  end

  task automatic drive(input logic r, input logic [2:0] fen, input logic [2:0] fin,
                       input logic br, input logic brreg, input logic [2:0] c,
                       input logic [8:0] imm, input logic [15:0] tgt,
                       input logic hlt, input logic stl);
    rst = r; flags_en = fen; flags_in = fin; is_branch = br; is_br_reg = brreg;
    cond = c; imm9 = imm; reg_target = tgt; is_hlt = hlt; stall = stl;
  endtask

  // Queue this cycle's expectations, then advance past the next active edge.
  task automatic step(input logic [15:0] pc, input logic tk, input logic h,
                      input logic [2:0] fl, input string name);
    exp_t e;
    e.pc = pc; e.tk = tk; e.h = h; e.fl = fl; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    drive(r, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 9'h000, 16'h0000, 1'b0, 1'b0);
  endtask

  logic [15:0] pb;

  initial begin
    pb = Byp ? 16'h144B : 16'h1443;
    idle(1'b1);                           step(16'h0000, 0, 0, 3'b000, "reset");
    idle(1'b0);                           step(16'h0000, 0, 0, 3'b000, "seq0");
    idle(1'b0);                           step(16'h0002, 0, 0, 3'b000, "seq1");
    idle(1'b0);                           step(16'h0004, 0, 0, 3'b000, "seq2");
    idle(1'b0);                           step(16'h0006, 0, 0, 3'b000, "seq3");
    drive(0, 3'b010, 3'b010, 0, 0, 3'b000, 9'h000, 16'h0, 0, 0);
                                          step(16'h0008, 0, 0, 3'b000, "setz");
    idle(1'b0);                           step(16'h000A, 0, 0, 3'b010, "zset");
    drive(0, 3'b000, 3'b000, 0, 0, 3'b000, 9'h000, 16'h0, 1, 1);
                                          step(16'h000C, 0, 0, 3'b010, "stall_hlt");
    idle(1'b0);                           step(16'h000C, 0, 0, 3'b010, "stall_held");
    idle(1'b0);                           step(16'h000E, 0, 0, 3'b010, "to10");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b001, 9'h1FE, 16'h0, 0, 0);
                                          step(16'h0010, 1, 0, 3'b010, "b_eq_back");
    drive(0, 3'b111, 3'b000, 0, 0, 3'b000, 9'h000, 16'h0, 0, 0);
                                          step(16'h000E, 0, 0, 3'b010, "b_target");
    drive(0, 3'b010, 3'b111, 0, 0, 3'b000, 9'h000, 16'h0, 0, 0);
                                          step(16'h0010, 0, 0, 3'b000, "clr_flags");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b110, 9'h000, 16'h0, 0, 0);
                                          step(16'h0012, 0, 0, 3'b010, "partial_en_ovf");
    drive(0, 3'b000, 3'b000, 1, 1, 3'b111, 9'h000, 16'hFFFE, 0, 0);
                                          step(16'h0014, 1, 0, 3'b010, "br_fffe");
    idle(1'b0);                           step(16'hFFFE, 0, 0, 3'b010, "at_fffe");
    drive(0, 3'b000, 3'b000, 1, 1, 3'b111, 9'h000, 16'h1234, 0, 0);
                                          step(16'h0000, 1, 0, 3'b010, "wrap_br1234");
    drive(0, 3'b000, 3'b000, 1, 1, 3'b111, 9'h000, 16'h1235, 0, 0);
                                          step(16'h1234, 1, 0, 3'b010, "br_odd");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b000, 9'h005, 16'h0, 0, 0);
                                          step(16'h1235, 0, 0, 3'b010, "b_ne_false");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b100, 9'h0FF, 16'h0, 0, 0);
                                          step(16'h1237, 1, 0, 3'b010, "b_ge_fwd");
    drive(0, 3'b111, 3'b100, 0, 0, 3'b000, 9'h000, 16'h0, 0, 0);
                                          step(16'h1437, 0, 0, 3'b010, "set_n");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b010, 9'h010, 16'h0, 0, 0);
                                          step(16'h1439, 0, 0, 3'b100, "b_gt_false");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b011, 9'h001, 16'h0, 0, 0);
                                          step(16'h143B, 1, 0, 3'b100, "b_lt_true");
    drive(0, 3'b111, 3'b011, 1, 0, 3'b111, 9'h010, 16'h0, 0, 1);
                                          step(16'h143F, 1, 0, 3'b100, "stall_branch");
    idle(1'b0);                           step(16'h143F, 0, 0, 3'b100, "stall_hold");
    drive(0, 3'b010, 3'b010, 1, 0, 3'b001, 9'h004, 16'h0, 0, 0);
                                          step(16'h1441, Byp, 0, 3'b100, "bypass_eq");
    idle(1'b0);                           step(pb, 0, 0, 3'b110, "bypass_pc");
    drive(0, 3'b000, 3'b000, 1, 0, 3'b111, 9'h004, 16'h0, 1, 0);
                                          step(pb + 16'd2, 0, 0, 3'b110, "hlt_vs_branch");
    drive(0, 3'b111, 3'b001, 1, 0, 3'b111, 9'h004, 16'h0, 0, 0);
                                          step(pb + 16'd2, 0, 1, 3'b110, "halted1");
    drive(0, 3'b000, 3'b000, 1, 1, 3'b111, 9'h000, 16'h5555, 0, 0);
                                          step(pb + 16'd2, 0, 1, 3'b110, "halted2");
    idle(1'b1);                           step(16'h0000, 0, 0, 3'b000, "rst_async");
    idle(1'b0);                           step(16'h0000, 0, 0, 3'b000, "post_rst0");
    idle(1'b0);                           step(16'h0002, 0, 0, 3'b000, "post_rst1");
    #10;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: flags_in  input  3  ALU flags, bit2=N, bit1=Z, bit0=V.
REQ-004 SHALL have port: flags_en  input  3  per-bit flag write enable, same bit order as flags_in.
REQ-005 SHALL have port: is_branch  input  1  current instruction is B or BR.
REQ-006 SHALL have port: is_br_reg  input  1  branch target from register (BR) rather than immediate (B).
REQ-007 SHALL have port: cond  input  3  branch condition code.
REQ-008 SHALL have port: imm9  input  9  signed word offset for B.
REQ-009 SHALL have port: reg_target  input  16  BR target address.
REQ-010 SHALL have port: is_hlt  input  1  current instruction is HLT.
REQ-011 SHALL have port: stall  input  1  hold PC this cycle.
REQ-012 SHALL have port: pc_out  output  16  current PC register.
REQ-013 SHALL have port: pc_plus2  output  16  pc_out+2, combinational.
REQ-014 SHALL have port: taken  output  1  combinational, branch taken this cycle.
REQ-015 SHALL have port: halt  output  1  registered, high in HALTED state.
REQ-016 SHALL have port: flags_q  output  3  registered flag state.

Function
REQ-017 SHALL update flags_q[i] <= flags_in[i] on each edge where flags_en[i]=1, state RUN and stall=0; other bits hold.
REQ-018 SHALL evaluate cond as: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-019 SHALL assert taken = is_branch & cond-true & state RUN & !is_hlt.
REQ-020 SHALL compute B target = pc_plus2 + (sign_extend(imm9) << 1), modulo 2^16.
REQ-021 SHALL compute BR target = reg_target unmodified, including odd values.
REQ-022 SHALL compute next PC: stall -> hold; is_hlt -> hold; taken -> target; else pc_plus2.
REQ-023 SHALL wrap PC arithmetic: 0xFFFE+2 = 0x0000, with no flag or error.
REQ-024 SHALL implement states RUN and HALTED; RUN->HALTED on edge with is_hlt=1 and stall=0; HALTED exits only via rst.
REQ-025 SHALL, in HALTED, hold pc_out and flags_q, force taken=0, and ignore all inputs.
REQ-026 SHALL give is_hlt priority over is_branch when both are high.
REQ-027 SHALL, when stall=1, suppress flag writes and state transitions while still driving taken combinationally.
REQ-028 SHALL have zero latency for branch resolution: a taken branch sets pc_out to target on the next edge.

Reset
REQ-029 SHALL on rst=1, independent of clk, force pc_out=0x0000, flags_q=3'b000, state RUN, halt=0.
REQ-030 SHALL, when rst asserts mid-branch or mid-HLT, discard the pending update; first post-reset edge fetches from 0x0002 path (PC 0 then +2).

Configuration
REQ-031 SHALL support macro FLAG_BYPASS_EN: defined -> cond evaluates merged flags (flags_in where flags_en=1, else flags_q) in the same cycle; undefined -> cond evaluates flags_q only.

Structure
REQ-032 SHALL place cond encodings, flag bit indices, and state encoding in shared package wisc_pkg.
REQ-033 SHALL contain one sub-module cond_eval (combinational cond x flags -> true).

Verification
REQ-034 SHALL test: rst, then 3 cycles no branch -> pc_out 0x0000, 0x0002, 0x0004, 0x0006.
REQ-035 SHALL test: pc_out=0x0010, flags_q Z=1, B cond=001 imm9=0x1FE (-2) -> taken=1, next pc_out=0x000E.
REQ-036 SHALL test: flags_en=3'b010, flags_in=3'b111 -> flags_q=3'b010 only; then cond=110 -> taken=0.
REQ-037 SHALL test: pc_out=0xFFFE, no branch -> next pc_out=0x0000; BR reg_target=0x1234 cond=111 -> 0x1234.
REQ-038 SHALL test: is_hlt=1 and is_branch=1 cond=111 -> taken=0, halt=1 next edge, pc_out frozen; rst -> pc_out 0, halt 0.
REQ-039 SHALL test with FLAG_BYPASS_EN: flags_q Z=0, flags_en=010 flags_in Z=1, cond=001 -> taken=1 same cycle; without macro -> taken=0.
